alarm_ring_ctrl: RTL and testbench
==================================

Name: alarm_ring_ctrl

Overview:
- Downstream consumer of the alarm-hour/alarm-minute BCD setters.
- Compares the stored alarm time (HH:MM, BCD) against the running clock time.
- On a match, runs a ring/snooze/timeout state machine and drives the buzzer and status outputs to the display/LED stage.

Parameters:
- RING_SECS, 60: 1 Hz ticks spent in RINGING before auto-stop.
- SNOOZE_SECS, 300: 1 Hz ticks spent in SNOOZE before re-ringing.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; further snooze presses act as stop.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse per second, clk-synchronous
- alarm_en  in  1  alarm armed switch
- mode_alarm  in  1  alarm-setting mode active; masks matching
- t_first  in  4  current minute ones, BCD 0-9
- t_second  in  4  current minute tens, BCD 0-5
- t_third  in  4  current hour ones, BCD 0-9
- t_fourth  in  4  current hour tens, BCD 0-2
- a_first  in  4  alarm minute ones
- a_second  in  4  alarm minute tens
- a_third  in  4  alarm hour ones
- a_fourth  in  4  alarm hour tens
- stop_pulse  in  1  debounced one-cycle stop request
- snooze_pulse  in  1  debounced one-cycle snooze request
- buzzer  out  1  buzzer drive
- ringing  out  1  high in RINGING
- snoozing  out  1  high in SNOOZE
- snooze_cnt  out  2  snoozes used in current event

Behaviour:
- Reset: every state register updates on posedge clk only; rst has priority over all other inputs.
  - state goes to IDLE; buzzer, ringing, snoozing and snooze_cnt are 0; timers and match_q are 0.
- Match: match = (all four t_* equal the corresponding a_*) and alarm_en and not mode_alarm.
  - match_q is registered.
  - trigger = match and not match_q, so there is only one trigger per matching minute.
  - Stopping inside the matching minute does not retrigger.
- States: IDLE, RINGING, SNOOZE. All outputs are registered.
- IDLE: on trigger, go to RINGING. Clear the timer and snooze_cnt. buzzer = 1 from the next edge, giving 1-cycle latency from the matching digits.
- RINGING: timer counts tick_1hz. Priority order:
  1. stop_pulse: go to IDLE, clear snooze_cnt.
  2. snooze_pulse with snooze_cnt < MAX_SNOOZE: go to SNOOZE, increment snooze_cnt, clear the timer.
  3. snooze_pulse with snooze_cnt == MAX_SNOOZE: treated as stop.
  4. Timer reaches RING_SECS-1 and tick_1hz is high: auto-stop to IDLE.
- SNOOZE: buzzer = 0.
  - Timer counts tick_1hz; at SNOOZE_SECS-1 with a tick, go to RINGING and clear the timer.
  - stop_pulse: go to IDLE, clear snooze_cnt.
  - snooze_pulse is ignored.
- alarm_en low in any state: go to IDLE next edge. Outranks stop/snooze.
- mode_alarm does not abort RINGING/SNOOZE. It only masks new triggers.
- Simultaneous stop and snooze: stop wins.
- Simultaneous trigger and any press while in IDLE: the press is ignored and trigger wins.
- Timer width: $clog2(max(RING_SECS,SNOOZE_SECS)). It never wraps; it saturates at the terminal value until the transition.
- snooze_cnt saturates at MAX_SNOOZE. MAX_SNOOZE must be ≤ 3.
- Digits are assumed valid BCD; invalid codes are compared bitwise with no correction.

Optional Feature:
- ALARM_BEEP_EN defined:
  - In RINGING, buzzer toggles on each tick_1hz, giving a 0.5 Hz on/off beep. It starts at 1 on entry.
  - ringing stays steady high.
- ALARM_BEEP_EN undefined: buzzer = ringing (steady tone).

Decomposition:
- alarm_pkg holds:
  - state enum (IDLE, RINGING, SNOOZE);
  - bcd_digit_t (4-bit);
  - default constants for RING_SECS, SNOOZE_SECS, MAX_SNOOZE.
- One sub-module, bcd_hhmm_match: combinational 4-digit equality producing match. It is reusable by the display blink logic.

Test Plan (bench uses RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2, tick every 10 clk):
- alarm 07:30, time steps 07:29 → 07:30 with alarm_en=1 → buzzer=1 and ringing=1 exactly 1 clk after the digits change. After 4 ticks with no press: IDLE, buzzer=0.
- Ringing at 07:30, stop_pulse → IDLE next clk. Time held at 07:30 for 20 ticks → no retrigger. Time 07:31 → 07:30 again → retriggers.
- Ringing, snooze_pulse → snoozing=1, snooze_cnt=1, buzzer=0; after 3 ticks → ringing=1. Snooze again → cnt=2. Third snooze_pulse → IDLE, cnt=0.
- Ringing, stop_pulse and snooze_pulse in the same clk → IDLE, snooze_cnt=0.
- Time matches while mode_alarm=1 or alarm_en=0 → no ring. Ringing, then alarm_en→0 → IDLE next clk.
- rst asserted mid-SNOOZE → all outputs 0, IDLE next clk.
- With ALARM_BEEP_EN: buzzer pattern 1,0,1,0 across successive ticks while ringing=1.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm ring controller
// and its BCD time-compare helper.
package alarm_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRinging,
      StSnooze
   } alarm_state_e;

   typedef logic [3:0] bcd_digit_t;

   localparam int unsigned RingSecsDefault   = 60;
   localparam int unsigned SnoozeSecsDefault = 300;
   localparam int unsigned MaxSnoozeDefault  = 3;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bcd_hhmm_match.sv
// Combinational HH:MM equality of two 4-digit BCD times; digits are compared
// bitwise, so invalid codes are not normalised.
module bcd_hhmm_match (
   input  logic [3:0] t_first_i,
   input  logic [3:0] t_second_i,
   input  logic [3:0] t_third_i,
   input  logic [3:0] t_fourth_i,
   input  logic [3:0] a_first_i,
   input  logic [3:0] a_second_i,
   input  logic [3:0] a_third_i,
   input  logic [3:0] a_fourth_i,
   output logic       match_o
);

   assign match_o = (t_first_i  == a_first_i)  &&
                    (t_second_i == a_second_i) &&
                    (t_third_i  == a_third_i)  &&
                    (t_fourth_i == a_fourth_i);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze/timeout controller. Define ALARM_BEEP_EN for a 0.5 Hz
// on/off buzzer while ringing; otherwise the buzzer is a steady tone.
module alarm_ring_ctrl
   import alarm_pkg::*;
#(
   parameter int unsigned RING_SECS   = RingSecsDefault,
   parameter int unsigned SNOOZE_SECS = SnoozeSecsDefault,
   parameter int unsigned MAX_SNOOZE  = MaxSnoozeDefault
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       alarm_en,
   input  logic       mode_alarm,
   input  logic [3:0] t_first,
   input  logic [3:0] t_second,
   input  logic [3:0] t_third,
   input  logic [3:0] t_fourth,
   input  logic [3:0] a_first,
   input  logic [3:0] a_second,
   input  logic [3:0] a_third,
   input  logic [3:0] a_fourth,
   input  logic       stop_pulse,
   input  logic       snooze_pulse,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] snooze_cnt
);

   localparam int unsigned TimerMax = max_u(RING_SECS, SNOOZE_SECS);
   localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;
   localparam logic [TimerW-1:0] RingLast   = TimerW'(RING_SECS - 1);
   localparam logic [TimerW-1:0] SnoozeLast = TimerW'(SNOOZE_SECS - 1);
   localparam logic [1:0]        MaxCnt     = 2'(MAX_SNOOZE);

   alarm_state_e      state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [1:0]        snooze_cnt_q, snooze_cnt_d;
   logic              match_q, match_d;
   logic              buzzer_q, buzzer_d;
   logic              ringing_q, ringing_d;
   logic              snoozing_q, snoozing_d;
   logic              time_eq;
   logic              trigger;

   bcd_hhmm_match u_match (
      .t_first_i  (t_first),
      .t_second_i (t_second),
      .t_third_i  (t_third),
      .t_fourth_i (t_fourth),
      .a_first_i  (a_first),
      .a_second_i (a_second),
      .a_third_i  (a_third),
      .a_fourth_i (a_fourth),
      .match_o    (time_eq)
   );

   assign match_d = time_eq && alarm_en && !mode_alarm;
   // Edge of the match: one trigger per matching minute.
   assign trigger = match_d && !match_q;

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      snooze_cnt_d = snooze_cnt_q;

      case (state_q)
         StIdle: begin
            if (trigger) begin
               state_d      = StRinging;
               timer_d      = '0;
               snooze_cnt_d = '0;
            end
         end
         StRinging: begin
            if (stop_pulse) begin
               state_d = StIdle;
            end else if (snooze_pulse) begin
               if (snooze_cnt_q < MaxCnt) begin
                  state_d      = StSnooze;
                  snooze_cnt_d = snooze_cnt_q + 2'd1;
                  timer_d      = '0;
               end else begin
                  state_d = StIdle;
               end
            end else if (tick_1hz) begin
               if (timer_q >= RingLast) begin
                  state_d = StIdle;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end
         StSnooze: begin
            if (stop_pulse) begin
               state_d = StIdle;
            end else if (tick_1hz) begin
               if (timer_q >= SnoozeLast) begin
                  state_d = StRinging;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (!alarm_en) begin
         state_d = StIdle;
      end
      if (state_d == StIdle) begin
         timer_d      = '0;
         snooze_cnt_d = '0;
      end
   end

   always_comb begin
      ringing_d  = (state_d == StRinging);
      snoozing_d = (state_d == StSnooze);
`ifdef ALARM_BEEP_EN
      buzzer_d = 1'b0;
      if (state_d == StRinging) begin
         // Start on at entry, then flip once per second.
         if (state_q != StRinging) begin
            buzzer_d = 1'b1;
         end else begin
            buzzer_d = tick_1hz ? !buzzer_q : buzzer_q;
         end
      end
`else
      buzzer_d = ringing_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         snooze_cnt_q <= '0;
         match_q      <= 1'b0;
         buzzer_q     <= 1'b0;
         ringing_q    <= 1'b0;
         snoozing_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         snooze_cnt_q <= snooze_cnt_d;
         match_q      <= match_d;
         buzzer_q     <= buzzer_d;
         ringing_q    <= ringing_d;
         snoozing_q   <= snoozing_d;
      end
   end

   assign buzzer     = buzzer_q;
   assign ringing    = ringing_q;
   assign snoozing   = snoozing_q;
   assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_alarm_ring_ctrl;

   localparam int unsigned RingSecs   = 4;
   localparam int unsigned SnoozeSecs = 3;
   localparam int unsigned MaxSnooze  = 2;
`ifdef ALARM_BEEP_EN
   localparam bit Beep = 1'b1;
`else
   localparam bit Beep = 1'b0;
`endif

   typedef struct {
      string      name;
      logic       buzzer;
      logic       ringing;
      logic       snoozing;
      logic [1:0] cnt;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       tick_1hz;
   logic       alarm_en;
   logic       mode_alarm;
   logic [3:0] t_first, t_second, t_third, t_fourth;
   logic [3:0] a_first, a_second, a_third, a_fourth;
   logic       stop_pulse;
   logic       snooze_pulse;
   logic       buzzer;
   logic       ringing;
   logic       snoozing;
   logic [1:0] snooze_cnt;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   alarm_ring_ctrl #(
      .RING_SECS   (RingSecs),
      .SNOOZE_SECS (SnoozeSecs),
      .MAX_SNOOZE  (MaxSnooze)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tick_1hz     (tick_1hz),
      .alarm_en     (alarm_en),
      .mode_alarm   (mode_alarm),
      .t_first      (t_first),
      .t_second     (t_second),
      .t_third      (t_third),
      .t_fourth     (t_fourth),
      .a_first      (a_first),
      .a_second     (a_second),
      .a_third      (a_third),
      .a_fourth     (a_fourth),
      .stop_pulse   (stop_pulse),
      .snooze_pulse (snooze_pulse),
      .buzzer       (buzzer),
      .ringing      (ringing),
      .snoozing     (snoozing),
      .snooze_cnt   (snooze_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: compares every queued expectation at the following negedge.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (buzzer !== e.buzzer || ringing !== e.ringing ||
             snoozing !== e.snoozing || snooze_cnt !== e.cnt) begin
            n_bad++;
            $display("FAIL %s: got buz=%b ring=%b snz=%b cnt=%0d, want buz=%b ring=%b snz=%b cnt=%0d",
                     e.name, buzzer, ringing, snoozing, snooze_cnt,
                     e.buzzer, e.ringing, e.snoozing, e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      repeat (9) step();
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
   endtask

   task automatic set_time(input logic [3:0] h10, input logic [3:0] h1,
                           input logic [3:0] m10, input logic [3:0] m1);
      t_fourth = h10;
      t_third  = h1;
      t_second = m10;
      t_first  = m1;
   endtask

   task automatic expect_out(input string name, input logic b, input logic r,
                             input logic s, input logic [1:0] c);
      exp_t e;
      e.name     = name;
      e.buzzer   = b;
      e.ringing  = r;
      e.snoozing = s;
      e.cnt      = c;
      exp_q.push_back(e);
   endtask

   // Re-arm the minute edge: 07:31 then back to 07:30.
   task automatic retrigger();
      set_time(0, 7, 3, 1);
      step();
      set_time(0, 7, 3, 0);
      step();
   endtask

   initial begin
      rst = 1'b1;
      tick_1hz = 1'b0;
      alarm_en = 1'b1;
      mode_alarm = 1'b0;
      stop_pulse = 1'b0;
      snooze_pulse = 1'b0;
      a_fourth = 4'd0;
      a_third  = 4'd7;
      a_second = 4'd3;
      a_first  = 4'd0;
      set_time(0, 7, 2, 9);
      step();
      step();
      expect_out("reset", 0, 0, 0, 0);
      rst = 1'b0;
      step();
      expect_out("idle_0729", 0, 0, 0, 0);

      // Trigger latency and auto-stop
      set_time(0, 7, 3, 0);
      expect_out("no_early_ring", 0, 0, 0, 0);
      step();
      expect_out("trig_latency", 1, 1, 0, 0);
      for (int k = 1; k < int'(RingSecs); k++) begin
         do_tick();
         expect_out("ring_tick", Beep ? ((k % 2) == 0) : 1'b1, 1, 0, 0);
      end
      do_tick();
      expect_out("autostop", 0, 0, 0, 0);
      repeat (3) step();
      expect_out("no_retrig_after_autostop", 0, 0, 0, 0);

      // Stop, hold minute, retrigger
      retrigger();
      expect_out("trig2", 1, 1, 0, 0);
      stop_pulse = 1'b1;
      step();
      stop_pulse = 1'b0;
      expect_out("stop", 0, 0, 0, 0);
      repeat (20) do_tick();
      expect_out("hold_no_retrig", 0, 0, 0, 0);
      retrigger();
      expect_out("retrig", 1, 1, 0, 0);

      // Snooze sequence
      snooze_pulse = 1'b1;
      step();
      snooze_pulse = 1'b0;
      expect_out("snooze1", 0, 0, 1, 1);
      snooze_pulse = 1'b1;
      step();
      snooze_pulse = 1'b0;
      expect_out("snooze_ignored_in_snooze", 0, 0, 1, 1);
      do_tick();
      do_tick();
      expect_out("snooze_2ticks", 0, 0, 1, 1);
      do_tick();
      expect_out("resume1", 1, 1, 0, 1);
      snooze_pulse = 1'b1;
      step();
      snooze_pulse = 1'b0;
      expect_out("snooze2", 0, 0, 1, 2);
      repeat (3) do_tick();
      expect_out("resume2", 1, 1, 0, 2);
      snooze_pulse = 1'b1;
      step();
      snooze_pulse = 1'b0;
      expect_out("snooze_as_stop", 0, 0, 0, 0);

      // Stop and snooze together
      retrigger();
      expect_out("trig4", 1, 1, 0, 0);
      stop_pulse = 1'b1;
      snooze_pulse = 1'b1;
      step();
      stop_pulse = 1'b0;
      snooze_pulse = 1'b0;
      expect_out("stop_snooze_same", 0, 0, 0, 0);

      // Masking by mode_alarm and alarm_en
      mode_alarm = 1'b1;
      retrigger();
      step();
      expect_out("mode_mask", 0, 0, 0, 0);
      set_time(0, 7, 3, 1);
      step();
      mode_alarm = 1'b0;
      alarm_en = 1'b0;
      set_time(0, 7, 3, 0);
      step();
      step();
      expect_out("en_mask", 0, 0, 0, 0);
      alarm_en = 1'b1;
      retrigger();
      expect_out("trig5", 1, 1, 0, 0);
      alarm_en = 1'b0;
      step();
      expect_out("en_off_abort", 0, 0, 0, 0);
      alarm_en = 1'b1;
      step();
      expect_out("en_rearm_trig", 1, 1, 0, 0);
      mode_alarm = 1'b1;
      step();
      expect_out("mode_no_abort", 1, 1, 0, 0);
      mode_alarm = 1'b0;

      // Reset mid-snooze
      snooze_pulse = 1'b1;
      step();
      snooze_pulse = 1'b0;
      expect_out("snooze_before_rst", 0, 0, 1, 1);
      rst = 1'b1;
      step();
      expect_out("rst_mid_snooze", 0, 0, 0, 0);
      rst = 1'b0;

      step();
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
